// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
//
// Turns raw active-low push-button inputs into clean, debounced events for the
// stopwatch control. Every key is handled by its own independent slice:
//   - 2-flop synchroniser (s1 -> s2) to tame the asynchronous button line
//   - 4-state debounce FSM (RELEASED / PRESS_WAIT / PRESSED / RELEASE_WAIT)
//   - long-press detector that fires at most once per accepted press
//   - registered debounced level
//
// Parameters:
//   NUM_KEYS        number of keys; bit i of every vector belongs to key i
//   DEBOUNCE_CYCLES consecutive stable samples to accept a press/release (>= 2)
//   LONG_CYCLES     cycles after an accepted press until key_long (0 = off)
//   CNT_W           per-key counter width, must hold max(DEBOUNCE, LONG)
//
// Ports:
//   clk          in   single clock, everything on the rising edge
//   reset        in   synchronous active-high reset
//   key_n_in     in   [NUM_KEYS] raw buttons, 0 = pressed
//   key_level    out  [NUM_KEYS] debounced state, 1 = pressed
//   key_press    out  [NUM_KEYS] one-cycle pulse per accepted press
//   key_release  out  [NUM_KEYS] one-cycle pulse per accepted release
//   key_long     out  [NUM_KEYS] one-cycle pulse, at most once per press
// ---------------------------------------------------------------------------
module key_conditioner #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int CNT_W           = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // Compare values are precomputed at full counter width so the per-key
    // comparisons are plain equality checks.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = (LONG_CYCLES > 0) ? CNT_W'(LONG_CYCLES - 1)
                                                               : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam bit               LONG_EN   = (LONG_CYCLES != 0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic             r_s1;
            logic             r_s2;
            state_t           r_state;
            logic [CNT_W-1:0] r_cnt;
            logic             r_long_done;
            logic             r_level;
            logic             r_press;
            logic             r_release;
            logic             r_long;
            logic             w_p;

            // Synchronised key, 1 = pressed. The FSM looks at nothing else.
            assign w_p = ~r_s2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1        <= 1'b1;
                    r_s2        <= 1'b1;
                    r_state     <= ST_RELEASED;
                    r_cnt       <= {CNT_W{1'b0}};
                    r_long_done <= 1'b0;
                    r_level     <= 1'b0;
                    r_press     <= 1'b0;
                    r_release   <= 1'b0;
                    r_long      <= 1'b0;
                end else begin
                    r_s1      <= key_n_in[gi];
                    r_s2      <= r_s1;

                    // Event outputs are single-cycle strobes.
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_long    <= 1'b0;

                    // The level only changes on the two accepting transitions;
                    // every other transition stays inside the "released" pair
                    // (RELEASED/PRESS_WAIT) or the "pressed" pair
                    // (PRESSED/RELEASE_WAIT), so holding it is correct.
                    case (r_state)
                        ST_RELEASED: begin
                            if (w_p) begin
                                r_state <= ST_PRESS_WAIT;
                                r_cnt   <= CNT_ONE;
                            end else begin
                                r_cnt   <= {CNT_W{1'b0}};
                            end
                        end

                        ST_PRESS_WAIT: begin
                            if (!w_p) begin
                                // A bounce throws away the partial debounce.
                                r_state <= ST_RELEASED;
                                r_cnt   <= {CNT_W{1'b0}};
                            end else if (r_cnt == DEB_LAST) begin
                                r_state <= ST_PRESSED;
                                r_cnt   <= {CNT_W{1'b0}};
                                r_press <= 1'b1;
                                r_level <= 1'b1;
                            end else begin
                                r_cnt   <= r_cnt + CNT_ONE;
                            end
                        end

                        ST_PRESSED: begin
                            if (!w_p) begin
                                r_state <= ST_RELEASE_WAIT;
                                r_cnt   <= CNT_ONE;
                            end else if (LONG_EN && !r_long_done && (r_cnt == LONG_LAST)) begin
                                // Counter freezes here; long_done blocks refiring.
                                r_long      <= 1'b1;
                                r_long_done <= 1'b1;
                            end else if (LONG_EN && !r_long_done) begin
                                r_cnt <= r_cnt + CNT_ONE;
                            end
                            // With long-press disabled the counter simply rests
                            // at zero so it can never wrap.
                        end

                        ST_RELEASE_WAIT: begin
                            if (w_p) begin
                                // Release bounce: back to held, long_done kept
                                // so the same physical press cannot fire twice.
                                r_state <= ST_PRESSED;
                                r_cnt   <= {CNT_W{1'b0}};
                            end else if (r_cnt == DEB_LAST) begin
                                r_state     <= ST_RELEASED;
                                r_cnt       <= {CNT_W{1'b0}};
                                r_long_done <= 1'b0;
                                r_release   <= 1'b1;
                                r_level     <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + CNT_ONE;
                            end
                        end

                        default: begin
                            r_state <= ST_RELEASED;
                            r_cnt   <= {CNT_W{1'b0}};
                            r_level <= 1'b0;
                        end
                    endcase
                end
            end

            assign key_level[gi]   = r_level;
            assign key_press[gi]   = r_press;
            assign key_release[gi] = r_release;
            assign key_long[gi]    = r_long;
        end
    endgenerate

endmodule
